// File: rtl/latch_bank_arbiter_if.sv
// Bus between the requesters / latch bank and latch_bank_arbiter.
// Optional parity signals exist only when LATCH_ARB_PARITY_EN is defined.
interface latch_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      lat_d;
  logic               lat_en;
  logic [DW-1:0]      lat_q;
`ifdef LATCH_ARB_PARITY_EN
  logic               lat_par;
  logic               lat_qpar;

  // Arbiter view
  modport slave (
    input  req_valid, req_data, lat_q, lat_qpar,
    output req_ready, lat_d, lat_en, lat_par
  );

  // Requester / latch bank view
  modport master (
    output req_valid, req_data, lat_q, lat_qpar,
    input  req_ready, lat_d, lat_en, lat_par
  );
`else
  // Arbiter view
  modport slave (
    input  req_valid, req_data, lat_q,
    output req_ready, lat_d, lat_en
  );

  // Requester / latch bank view
  modport master (
    output req_valid, req_data, lat_q,
    input  req_ready, lat_d, lat_en
  );
`endif
endinterface

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin write controller owning the enable of a
// shared DW-bit D-latch bank. Each write runs SETUP -> PULSE -> HOLD so the
// latch data is stable on both sides of the enable gate, and the readback is
// compared in HOLD. Optional parity (lat_par / lat_qpar) is enabled by
// defining LATCH_ARB_PARITY_EN.
module latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  latch_bank_arbiter_if.slave      bus,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     wr_ok,
  output logic                     wr_err
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic            lat_en_q, lat_en_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            wr_err_q, wr_err_d;
  logic [CW-1:0]   en_cnt_q, en_cnt_d;
`ifdef LATCH_ARB_PARITY_EN
  logic            lat_par_q, lat_par_d;
`endif

  logic [DW-1:0]   slot [NREQ];
  logic            grant_found;
  logic [OW-1:0]   grant_idx;
  int              cand_i;
  logic [OW-1:0]   cand;
  logic            rb_match;

  // Split the packed request data into one word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = bus.req_data[i*DW +: DW];
  end

  // Round-robin search: first valid requester after owner, wrapping mod NREQ.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = owner_q;
    cand_i      = 0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_i = int'(owner_q) + off;
      if (cand_i >= NREQ) cand_i = cand_i - NREQ;
      cand = OW'(cand_i);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Readback check against the word (and parity) that was written.
`ifdef LATCH_ARB_PARITY_EN
  assign rb_match = (bus.lat_q == lat_d_q) && (bus.lat_qpar == lat_par_q);
`else
  assign rb_match = (bus.lat_q == lat_d_q);
`endif

  // Next-state and output decode for the write sequencer.
  always_comb begin
    state_d       = state_q;
    lat_d_d       = lat_d_q;
    lat_en_d      = 1'b0;
    owner_d       = owner_q;
    wr_err_d      = wr_err_q;
    en_cnt_d      = '0;
    bus.req_ready = '0;
    wr_ok         = 1'b0;
`ifdef LATCH_ARB_PARITY_EN
    lat_par_d     = lat_par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready = NREQ'(1) << grant_idx;
          lat_d_d       = slot[grant_idx];
          owner_d       = grant_idx;
          state_d       = SETUP;
`ifdef LATCH_ARB_PARITY_EN
          lat_par_d     = ^slot[grant_idx];
`endif
        end
      end
      SETUP: begin
        // Data has been stable for one full cycle; open the gate next edge.
        lat_en_d = 1'b1;
        state_d  = PULSE;
      end
      PULSE: begin
        if (en_cnt_q == CW'(EN_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          lat_en_d = 1'b1;
          en_cnt_d = en_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (rb_match) wr_ok    = 1'b1;
        else          wr_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An asserted reset aborts the cycle: no accept and no result pulse.
    if (rst) begin
      bus.req_ready = '0;
      wr_ok         = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      lat_d_q   <= '0;
      lat_en_q  <= 1'b0;
      owner_q   <= OW'(NREQ - 1);
      wr_err_q  <= 1'b0;
      en_cnt_q  <= '0;
`ifdef LATCH_ARB_PARITY_EN
      lat_par_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= lat_en_d;
      owner_q   <= owner_d;
      wr_err_q  <= wr_err_d;
      en_cnt_q  <= en_cnt_d;
`ifdef LATCH_ARB_PARITY_EN
      lat_par_q <= lat_par_d;
`endif
    end
  end

  assign bus.lat_d   = lat_d_q;
  assign bus.lat_en  = lat_en_q;
`ifdef LATCH_ARB_PARITY_EN
  assign bus.lat_par = lat_par_q;
`endif
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed testbench for latch_bank_arbiter (NREQ=4, DW=8, EN_CYCLES=2).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_latch_bank_arbiter;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] owner;
  logic       wr_ok;
  logic       wr_err;

  int n_checks;
  int n_errors;

  latch_bank_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  latch_bank_arbiter #(.NREQ(4), .DW(8), .EN_CYCLES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .owner  (owner),
    .wr_ok  (wr_ok),
    .wr_err (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural latch bank with injectable readback faults.
  logic [7:0] latch_store;
  logic       rb_fault;
  always_latch if (bus.lat_en) latch_store <= bus.lat_d;
  assign bus.lat_q = rb_fault ? 8'h00 : latch_store;

`ifdef LATCH_ARB_PARITY_EN
  logic par_store;
  logic par_fault;
  always_latch if (bus.lat_en) par_store <= bus.lat_par;
  assign bus.lat_qpar = par_fault ? 1'b0 : par_store;
`endif

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cyc();
    rst = 1'b1;
    bus.req_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h4433_2211;
    cyc();
    cyc();
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    n_checks++; if (bus.lat_d !== 8'h00) begin n_errors++; $display("FAIL reset_lat_d: got %h want 00", bus.lat_d); end
    n_checks++; if (bus.lat_en !== 1'b0) begin n_errors++; $display("FAIL reset_lat_en: got %b want 0", bus.lat_en); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd3) begin n_errors++; $display("FAIL reset_owner: got %0d want 3", owner); end
    n_checks++; if (wr_ok !== 1'b0 || wr_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got ok=%b err=%b want 0/0", wr_ok, wr_err); end
`ifdef LATCH_ARB_PARITY_EN
    n_checks++; if (bus.lat_par !== 1'b0) begin n_errors++; $display("FAIL reset_lat_par: got %b want 0", bus.lat_par); end
`endif
    cyc();
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_single_write();
    cyc();                                   // cycle 0
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_00A5;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
    cyc();                                   // cycle 1 (SETUP)
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.lat_d !== 8'hA5) begin n_errors++; $display("FAIL single_lat_d: got %h want a5", bus.lat_d); end
    n_checks++; if (bus.lat_en !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL single_setup: got en=%b busy=%b want 0/1", bus.lat_en, busy); end
    n_checks++; if (owner !== 2'd0) begin n_errors++; $display("FAIL single_owner: got %0d want 0", owner); end
    cyc(); #1;                               // cycle 2
    n_checks++; if (bus.lat_en !== 1'b1) begin n_errors++; $display("FAIL single_en_c2: got %b want 1", bus.lat_en); end
    cyc(); #1;                               // cycle 3
    n_checks++; if (bus.lat_en !== 1'b1) begin n_errors++; $display("FAIL single_en_c3: got %b want 1", bus.lat_en); end
    cyc(); #1;                               // cycle 4 (HOLD)
    n_checks++; if (bus.lat_en !== 1'b0 || wr_ok !== 1'b1) begin n_errors++; $display("FAIL single_hold: got en=%b ok=%b want 0/1", bus.lat_en, wr_ok); end
    n_checks++; if (bus.lat_d !== 8'hA5) begin n_errors++; $display("FAIL single_hold_d: got %h want a5", bus.lat_d); end
    cyc(); #1;                               // cycle 5 (IDLE)
    n_checks++; if (busy !== 1'b0 || wr_ok !== 1'b0 || wr_err !== 1'b0) begin n_errors++; $display("FAIL single_idle: got busy=%b ok=%b err=%b want 0/0/0", busy, wr_ok, wr_err); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
    int         k;
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h4433_2211;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) cyc();
      #1;
      k         = (c / 5) % 4;
      exp_ready = ((c % 5) == 0) ? (4'b0001 << k) : 4'b0000;
      exp_data  = {4'(k + 1), 4'(k + 1)};
      n_checks++; if (bus.req_ready !== exp_ready) begin n_errors++; $display("FAIL rr_ready c=%0d: got %b want %b", c, bus.req_ready, exp_ready); end
      if ((c % 5) == 1) begin
        n_checks++; if (bus.lat_d !== exp_data) begin n_errors++; $display("FAIL rr_lat_d c=%0d: got %h want %h", c, bus.lat_d, exp_data); end
      end
      if ((c % 5) == 4) begin
        n_checks++; if (wr_ok !== 1'b1) begin n_errors++; $display("FAIL rr_wr_ok c=%0d: got %b want 1", c, wr_ok); end
      end
    end
    cyc();
    bus.req_valid = '0;
  endtask

  task automatic test_priority_skip();
    cyc();                                   // owner is 0 here
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h005A_0000;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL prio_first: got %b want 0100", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    #1;
    n_checks++; if (owner !== 2'd2) begin n_errors++; $display("FAIL prio_owner2: got %0d want 2", owner); end
    repeat (4) cyc();                        // IDLE again
    bus.req_valid = 4'b0101;
    bus.req_data  = 32'h005A_00C3;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL prio_wrap: got %b want 0001", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    #1;
    n_checks++; if (owner !== 2'd0 || bus.lat_d !== 8'hC3) begin n_errors++; $display("FAIL prio_capture: got owner=%0d d=%h want 0/c3", owner, bus.lat_d); end
    repeat (3) cyc();
    #1;
    n_checks++; if (wr_ok !== 1'b1) begin n_errors++; $display("FAIL prio_wr_ok: got %b want 1", wr_ok); end
    cyc();
  endtask

  task automatic test_readback_fault();
    cyc();
    rb_fault      = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_3C00;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_errors++; $display("FAIL fault_ready: got %b want 0010", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    repeat (3) cyc();
    #1;                                      // HOLD of faulty write
    n_checks++; if (wr_ok !== 1'b0) begin n_errors++; $display("FAIL fault_no_ok: got %b want 0", wr_ok); end
    cyc(); #1;
    n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL fault_err_set: got %b want 1", wr_err); end
    rb_fault      = 1'b0;
    bus.req_valid = 4'b1000;
    bus.req_data  = 32'h8100_0000;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_errors++; $display("FAIL fault_good_ready: got %b want 1000", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    repeat (3) cyc();
    #1;
    n_checks++; if (wr_ok !== 1'b1) begin n_errors++; $display("FAIL fault_good_ok: got %b want 1", wr_ok); end
    cyc(); #1;
    n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL fault_err_sticky: got %b want 1", wr_err); end
    apply_reset();
    #1;
    n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL fault_err_clear: got %b want 0", wr_err); end
  endtask

  task automatic test_reset_mid_write();
    cyc();                                   // cycle 0, owner 3
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h7700_0099;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL abort_ready: got %b want 0001", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    cyc();                                   // cycle 2: first PULSE cycle
    cyc();                                   // cycle 3: second PULSE cycle
    #1;
    n_checks++; if (bus.lat_en !== 1'b1) begin n_errors++; $display("FAIL abort_pulse: got %b want 1", bus.lat_en); end
    rst           = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL abort_ready_rst: got %b want 0000", bus.req_ready); end
    cyc(); #1;                               // cycle 4, rst still high
    n_checks++; if (bus.lat_en !== 1'b0 || bus.lat_d !== 8'h00) begin n_errors++; $display("FAIL abort_latch: got en=%b d=%h want 0/00", bus.lat_en, bus.lat_d); end
    n_checks++; if (busy !== 1'b0 || owner !== 2'd3) begin n_errors++; $display("FAIL abort_state: got busy=%b owner=%0d want 0/3", busy, owner); end
    n_checks++; if (wr_ok !== 1'b0 || wr_err !== 1'b0 || bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL abort_flags: got ok=%b err=%b rdy=%b want 0/0/0000", wr_ok, wr_err, bus.req_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_errors++; $display("FAIL abort_pending: got %b want 1000", bus.req_ready); end
    cyc();                                   // cycle 5
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.lat_d !== 8'h77 || owner !== 2'd3 || busy !== 1'b1) begin n_errors++; $display("FAIL abort_next: got d=%h owner=%0d busy=%b want 77/3/1", bus.lat_d, owner, busy); end
    repeat (3) cyc();
    #1;                                      // cycle 8: HOLD
    n_checks++; if (wr_ok !== 1'b1) begin n_errors++; $display("FAIL abort_next_ok: got %b want 1", wr_ok); end
    cyc(); #1;
    n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL abort_no_err: got %b want 0", wr_err); end
  endtask

`ifdef LATCH_ARB_PARITY_EN
  task automatic test_parity();
    cyc();                                   // owner 3 -> grant 0
    par_fault     = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0007;
    cyc();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.lat_par !== 1'b1) begin n_errors++; $display("FAIL par_bit: got %b want 1", bus.lat_par); end
    repeat (3) cyc();
    #1;
    n_checks++; if (wr_ok !== 1'b0) begin n_errors++; $display("FAIL par_no_ok: got %b want 0", wr_ok); end
    cyc(); #1;
    n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL par_err: got %b want 1", wr_err); end
    par_fault = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    rb_fault      = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef LATCH_ARB_PARITY_EN
    par_fault     = 1'b0;
`endif
    test_reset();
    test_single_write();
    test_round_robin();
    test_priority_skip();
    test_readback_fault();
    test_reset_mid_write();
`ifdef LATCH_ARB_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
